// File: rtl/apb_arb2.sv
// apb_arb2: two-requester APB arbiter in front of one shared APB completer.
// The arbiter grants round-robin, runs one full setup/access transfer for the
// winner, and routes the response back to that requester only. If the
// completer stalls, a timeout ends the access with an error response.
//
// Ports:
//   clk, rstn                     clock; asynchronous active-low reset
//   sN_psel/penable/pwrite/paddr/pwdata (N=0,1)  upstream requests
//   sN_prdata/pready/pslverr      upstream response; combinational, valid
//                                 only for the granted port
//   m_psel/penable/pwrite/paddr/pwdata           downstream request (registered)
//   m_prdata/pready/pslverr       downstream response
module apb_arb2 #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  s0_psel,
  input  logic                  s0_penable,
  input  logic                  s0_pwrite,
  input  logic [ADDR_WIDTH-1:0] s0_paddr,
  input  logic [DATA_WIDTH-1:0] s0_pwdata,
  output logic [DATA_WIDTH-1:0] s0_prdata,
  output logic                  s0_pready,
  output logic                  s0_pslverr,
  input  logic                  s1_psel,
  input  logic                  s1_penable,
  input  logic                  s1_pwrite,
  input  logic [ADDR_WIDTH-1:0] s1_paddr,
  input  logic [DATA_WIDTH-1:0] s1_pwdata,
  output logic [DATA_WIDTH-1:0] s1_prdata,
  output logic                  s1_pready,
  output logic                  s1_pslverr,
  output logic                  m_psel,
  output logic                  m_penable,
  output logic                  m_pwrite,
  output logic [ADDR_WIDTH-1:0] m_paddr,
  output logic [DATA_WIDTH-1:0] m_pwdata,
  input  logic [DATA_WIDTH-1:0] m_prdata,
  input  logic                  m_pready,
  input  logic                  m_pslverr
);

  // The counter only has to reach TIMEOUT-1; keep it at least one bit wide.
  localparam int unsigned   CW       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam bit            TO_EN    = (TIMEOUT != 0);
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t        state_q, state_d;
  logic          grant_q, grant_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          load;
  logic          gsel;
  logic          done;
  logic          timeout_hit;

  // penable is not part of arbitration; the request is psel alone.
  logic unused_penable;
  assign unused_penable = s0_penable ^ s1_penable;

  // Next-state, arbitration and completion decode.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    load        = 1'b0;
    gsel        = 1'b0;
    done        = 1'b0;
    timeout_hit = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (s0_psel || s1_psel) begin
          load    = 1'b1;
          gsel    = (s0_psel && s1_psel) ? ~last_q : s1_psel;
          grant_d = gsel;
          state_d = SETUP;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (m_pready) begin
          done    = 1'b1;
          last_d  = grant_q;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (TO_EN && (cnt_q == CNT_LAST)) begin
          done        = 1'b1;
          timeout_hit = 1'b1;
          last_d      = grant_q;
          cnt_d       = '0;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, arbitration bookkeeping and downstream request registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      grant_q   <= 1'b0;
      last_q    <= 1'b1;
      cnt_q     <= '0;
      m_psel    <= 1'b0;
      m_penable <= 1'b0;
      m_pwrite  <= 1'b0;
      m_paddr   <= '0;
      m_pwdata  <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      m_psel    <= (state_d != IDLE);
      m_penable <= (state_d == ACCESS);
      if (load) begin
        m_pwrite <= gsel ? s1_pwrite : s0_pwrite;
        m_paddr  <= gsel ? s1_paddr  : s0_paddr;
        m_pwdata <= gsel ? s1_pwdata : s0_pwdata;
      end
    end
  end

  // Response steering: a timeout forces error with zero data.
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_err;
  assign rsp_data = timeout_hit ? '0 : m_prdata;
  assign rsp_err  = timeout_hit | m_pslverr;

  assign s0_pready  = done & ~grant_q;
  assign s1_pready  = done &  grant_q;
  assign s0_pslverr = s0_pready & rsp_err;
  assign s1_pslverr = s1_pready & rsp_err;
  assign s0_prdata  = {DATA_WIDTH{s0_pready}} & rsp_data;
  assign s1_prdata  = {DATA_WIDTH{s1_pready}} & rsp_data;

endmodule

// File: tb/tb_apb_arb2.sv
// Self-checking bench for apb_arb2 (TIMEOUT=4) with a small completer model
// and per-port expected-response scoreboards.
module tb_apb_arb2;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 4;

  typedef struct packed {
    logic          err;
    logic [DW-1:0] data;
  } rsp_t;
  typedef enum int {M_READY, M_WAIT, M_STALL} mode_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   cyc = 0;

  logic          s_psel[2], s_penable[2], s_pwrite[2];
  logic [AW-1:0] s_paddr[2];
  logic [DW-1:0] s_pwdata[2];
  logic [DW-1:0] s0_prdata, s1_prdata;
  logic          s0_pready, s1_pready, s0_pslverr, s1_pslverr;
  logic          s_pready[2], s_pslverr[2];
  logic [DW-1:0] s_prdata[2];

  logic          m_psel, m_penable, m_pwrite;
  logic [AW-1:0] m_paddr;
  logic [DW-1:0] m_pwdata, m_prdata;
  logic          m_pready, m_pslverr;

  int n_checks = 0;
  int n_errors = 0;

  rsp_t exp_q0[$];
  rsp_t exp_q1[$];
  int   grant_log[$];

  // Completer model
  mode_t         mode = M_READY;
  int            nwait = 0;
  int            acc_cnt = 0;
  logic [DW-1:0] mem[256] = '{default: '0};
  logic [DW-1:0] shadow[256] = '{default: '0};

  apb_arb2 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rstn(rstn),
    .s0_psel(s_psel[0]), .s0_penable(s_penable[0]), .s0_pwrite(s_pwrite[0]),
    .s0_paddr(s_paddr[0]), .s0_pwdata(s_pwdata[0]), .s0_prdata(s0_prdata),
    .s0_pready(s0_pready), .s0_pslverr(s0_pslverr),
    .s1_psel(s_psel[1]), .s1_penable(s_penable[1]), .s1_pwrite(s_pwrite[1]),
    .s1_paddr(s_paddr[1]), .s1_pwdata(s_pwdata[1]), .s1_prdata(s1_prdata),
    .s1_pready(s1_pready), .s1_pslverr(s1_pslverr),
    .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
    .m_paddr(m_paddr), .m_pwdata(m_pwdata), .m_prdata(m_prdata),
    .m_pready(m_pready), .m_pslverr(m_pslverr)
  );

  assign s_pready[0]  = s0_pready;
  assign s_pready[1]  = s1_pready;
  assign s_pslverr[0] = s0_pslverr;
  assign s_pslverr[1] = s1_pslverr;
  assign s_prdata[0]  = s0_prdata;
  assign s_prdata[1]  = s1_prdata;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    case (mode)
      M_READY: m_pready = 1'b1;
      M_WAIT:  m_pready = (acc_cnt >= nwait);
      default: m_pready = 1'b0;
    endcase
  end
  assign m_prdata  = mem[m_paddr[9:2]];
  assign m_pslverr = m_paddr[11];

  always @(posedge clk) begin
    if (m_psel && m_penable && !m_pready) acc_cnt <= acc_cnt + 1;
    else if (!m_penable) acc_cnt <= 0;
    if (m_psel && m_penable && m_pready && m_pwrite) mem[m_paddr[9:2]] <= m_pwdata;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_mctl"}, 64'({m_psel, m_penable, m_pwrite}), 64'd0);
    check({pfx, "_maddr"}, 64'(m_paddr), 64'd0);
    check({pfx, "_mwdata"}, 64'(m_pwdata), 64'd0);
    check({pfx, "_sresp"}, 64'({s0_pready, s1_pready, s0_pslverr, s1_pslverr}), 64'd0);
    check({pfx, "_sprdata"}, 64'({s0_prdata, s1_prdata}), 64'd0);
  endtask

  // Issue one APB transfer on port p; expected response pushed at drive time.
  task automatic xfer(input int p, input bit wr, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, output int t0, output int tdone);
    rsp_t e;
    if (mode == M_STALL) begin
      e.err  = 1'b1;
      e.data = '0;
    end else begin
      e.err  = a[11];
      e.data = shadow[a[9:2]];
      if (wr) shadow[a[9:2]] = d;
    end
    if (p == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
    s_psel[p] = 1'b1; s_penable[p] = 1'b0; s_pwrite[p] = wr;
    s_paddr[p] = a;   s_pwdata[p] = d;
    t0 = cyc;
    tdone = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (s_pready[p]) begin
        tdone = cyc;
        break;
      end
      @(posedge clk); #1;
      s_penable[p] = 1'b1;
    end
    if (tdone < 0) check($sformatf("xfer%0d_no_pready", p), 64'd0, 64'd1);
    else begin
      @(posedge clk); #1;
    end
    s_psel[p] = 1'b0;
    s_penable[p] = 1'b0;
  endtask

  // Scoreboard: pop and compare on every pready; idle responses must be zero.
  always @(negedge clk) begin
    if (rstn) begin
      check("one_pready", 64'(s_pready[0] & s_pready[1]), 64'd0);
      for (int p = 0; p < 2; p++) begin
        if (s_pready[p]) begin
          rsp_t e;
          grant_log.push_back(p);
          if ((p == 0 && exp_q0.size() == 0) || (p == 1 && exp_q1.size() == 0)) begin
            check($sformatf("spurious_pready%0d", p), 64'd1, 64'd0);
          end else begin
            e = (p == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            check($sformatf("rsp_err%0d", p), 64'(s_pslverr[p]), 64'(e.err));
            check($sformatf("rsp_data%0d", p), 64'(s_prdata[p]), 64'(e.data));
          end
        end else begin
          check($sformatf("rsp_idle_zero%0d", p), 64'({s_pslverr[p], s_prdata[p]}), 64'd0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic simultaneous(input string pfx, input logic [AW-1:0] base);
    int ta, tda, tb, tdb;
    fork
      xfer(0, 1'b0, base,        '0, ta, tda);
      xfer(1, 1'b0, base + 32'h4, '0, tb, tdb);
    join
    check({pfx, "_p0_done"}, 64'(tda - ta), 64'd2);
    check({pfx, "_p1_done"}, 64'(tdb - tb), 64'd5);
  endtask

  initial begin
    int t0, td, n0, n1;
    for (int p = 0; p < 2; p++) begin
      s_psel[p] = 1'b0; s_penable[p] = 1'b0; s_pwrite[p] = 1'b0;
      s_paddr[p] = '0;  s_pwdata[p] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;

    // Simultaneous requests straight after reset: port 0 wins first.
    simultaneous("sim", 32'h20);

    // Single write then read on port 0 with a zero-wait completer.
    fork
      xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, t0, td);
      begin
        @(negedge clk);
        @(negedge clk);
        check("wr_setup_ctl", 64'({m_psel, m_penable, m_pwrite}), 64'b101);
        check("wr_setup_addr", 64'(m_paddr), 64'h10);
        @(negedge clk);
        check("wr_access_ctl", 64'({m_psel, m_penable}), 64'b11);
        check("wr_access_wdata", 64'(m_pwdata), 64'hDEADBEEF);
      end
    join
    check("wr_lat", 64'(td - t0), 64'd2);
    xfer(0, 1'b0, 32'h10, '0, t0, td);
    check("rd_lat", 64'(td - t0), 64'd2);

    // Completer error is passed through with data.
    xfer(1, 1'b0, 32'h810, '0, t0, td);

    // Fairness: both ports request continuously for 8 transfers.
    grant_log.delete();
    fork
      for (int i = 0; i < 4; i++) xfer(0, 1'b1, 32'h100 + 32'(i * 4), 32'hA000 + 32'(i), t0, td);
      for (int i = 0; i < 4; i++) xfer(1, 1'b1, 32'h200 + 32'(i * 4), 32'hB000 + 32'(i), t0, td);
    join
    n0 = 0; n1 = 0;
    foreach (grant_log[i]) if (grant_log[i] == 0) n0++; else n1++;
    check("fair_total", 64'(grant_log.size()), 64'd8);
    check("fair_n0", 64'(n0), 64'd4);
    check("fair_n1", 64'(n1), 64'd4);
    for (int i = 0; i + 1 < grant_log.size(); i++)
      check("fair_alternate", 64'(grant_log[i + 1]), 64'(1 - grant_log[i]));

    // Three wait states; request held stable downstream throughout.
    mode = M_WAIT; nwait = 3;
    fork
      xfer(0, 1'b1, 32'h40, 32'hA5A50001, t0, td);
      begin
        @(negedge clk);
        for (int k = 1; k <= 5; k++) begin
          @(negedge clk);
          check("wait_paddr", 64'(m_paddr), 64'h40);
          check("wait_pwdata", 64'(m_pwdata), 64'hA5A50001);
          check("wait_psel", 64'(m_psel), 64'd1);
        end
      end
    join
    check("wait_lat", 64'(td - t0), 64'd5);

    // Timeout on a stalled completer (address holds nonzero data).
    mode = M_STALL;
    xfer(1, 1'b0, 32'h10, '0, t0, td);
    check("to_lat", 64'(td - t0), 64'd5);
    check("to_psel_after", 64'(m_psel), 64'd0);

    // Reset in the middle of a stalled access: no response, outputs cleared.
    s_psel[0] = 1'b1; s_pwrite[0] = 1'b1; s_paddr[0] = 32'h44; s_pwdata[0] = 32'h1234;
    repeat (3) @(negedge clk);
    check("mid_pre_access", 64'({m_psel, m_penable}), 64'b11);
    #1 rstn = 1'b0;
    #1;
    check_all_zero("midrst");
    s_psel[0] = 1'b0; s_penable[0] = 1'b0; s_pwrite[0] = 1'b0;
    mode = M_READY;
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    simultaneous("post_rst", 32'h60);

    repeat (2) @(posedge clk);
    check("q0_empty", 64'(exp_q0.size()), 64'd0);
    check("q1_empty", 64'(exp_q1.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
